// File: rtl/centimos_euros_seq.sv
// -----------------------------------------------------------------------------
// centimos_euros_seq
//
// Sequential cents-to-euros converter. An unsigned amount in cents is split
// into whole units (euros = centimos / DIVISOR) and the leftover cents
// (cents = centimos % DIVISOR). A restoring divider resolves one quotient bit
// per clock, so no wide combinational divider is needed. Valid/ready
// handshakes are used on both the input and the output side.
//
// Optional feature (macro CENTIMOS_EUROS_BCD_EN):
//   When defined, adds output cents_bcd[7:0] = {tens, units} BCD of cents,
//   registered together with cents. The tens digit saturates at 9 for
//   DIVISOR > 100.
//
// Parameters:
//   W_IN     width of the input amount and of the euros output
//   DIVISOR  cents per unit, 2 <= DIVISOR < 2**W_IN
//   W_REM    (local) width of the cents output, $clog2(DIVISOR)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   amount presented
//   in_ready   out  amount can be accepted this cycle (combinational)
//   centimos   in   unsigned amount in cents [W_IN-1:0]
//   out_valid  out  result available
//   out_ready  in   consumer takes the result this cycle
//   euros      out  quotient [W_IN-1:0]
//   cents      out  remainder [W_REM-1:0]
//   busy       out  high while the division is running
//   cents_bcd  out  BCD of cents [7:0] (only with CENTIMOS_EUROS_BCD_EN)
// -----------------------------------------------------------------------------
module centimos_euros_seq #(
    parameter int W_IN    = 14,
    parameter int DIVISOR = 100,
    localparam int W_REM  = $clog2(DIVISOR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_IN-1:0]    centimos,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_IN-1:0]    euros,
    output logic [W_REM-1:0]   cents,
`ifdef CENTIMOS_EUROS_BCD_EN
    output logic [7:0]         cents_bcd,
`endif
    output logic               busy
);

    localparam int W_CNT = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam logic [W_CNT-1:0] CNT_INIT = W_CNT'(W_IN - 1);
    localparam logic [W_CNT-1:0] CNT_ONE  = W_CNT'(1);
    localparam logic [W_REM:0]   DIV_C    = (W_REM + 1)'(DIVISOR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W_IN-1:0]    dvd_q, dvd_d;      // dividend, refilled with quotient bits from the LSB
    logic [W_REM-1:0]   rem_q, rem_d;      // partial remainder, always < DIVISOR
    logic [W_CNT-1:0]   cnt_q, cnt_d;
    logic [W_IN-1:0]    euros_q, euros_d;
    logic [W_REM-1:0]   cents_q, cents_d;
    logic               out_valid_q, out_valid_d;

    logic [W_REM:0]     shifted_s;         // partial remainder with next dividend bit appended
    logic               ge_s;
    logic               in_ready_s;
    logic               accept_s;

`ifdef CENTIMOS_EUROS_BCD_EN
    logic [7:0]         bcd_q, bcd_d;

    // Binary cents to {tens, units} BCD; tens saturates at 9.
    function automatic logic [7:0] to_bcd(input logic [W_REM-1:0] v);
        int t;
        int u;
        t = int'(v) / 32'sd10;
        u = int'(v) % 32'sd10;
        if (t > 32'sd9) begin
            t = 32'sd9;
        end else begin
            t = t;
        end
        return {t[3:0], u[3:0]};
    endfunction
`endif

    // Since rem_q < DIVISOR <= 2**W_REM, the shifted value fits W_REM+1 bits.
    assign shifted_s  = {rem_q, dvd_q[W_IN-1]};
    assign ge_s       = (shifted_s >= DIV_C);
    assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign euros     = euros_q;
    assign cents     = cents_q;
    assign busy      = (state_q == DIV);

    // Next-state and datapath update for the divider FSM.
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        euros_d     = euros_q;
        cents_d     = cents_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    dvd_d   = centimos;
                    rem_d   = {W_REM{1'b0}};
                    cnt_d   = CNT_INIT;
                    state_d = DIV;
                end else begin
                    state_d = IDLE;
                end
            end

            DIV: begin
                // Quotient bit shifts in where the consumed dividend bit left.
                dvd_d = {dvd_q[W_IN-2:0], ge_s};
                rem_d = W_REM'(ge_s ? (shifted_s - DIV_C) : shifted_s);
                if (cnt_q == {W_CNT{1'b0}}) begin
                    euros_d     = {dvd_q[W_IN-2:0], ge_s};
                    cents_d     = W_REM'(ge_s ? (shifted_s - DIV_C) : shifted_s);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (in_valid) begin
                        // Hand-off and new capture share the same edge.
                        dvd_d   = centimos;
                        rem_d   = {W_REM{1'b0}};
                        cnt_d   = CNT_INIT;
                        state_d = DIV;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

`ifdef CENTIMOS_EUROS_BCD_EN
    // BCD follows cents_d, so it is loaded and held exactly like cents.
    always_comb begin
        bcd_d = to_bcd(cents_d);
    end

    // BCD output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_q <= 8'h00;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign cents_bcd = bcd_q;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dvd_q       <= {W_IN{1'b0}};
            rem_q       <= {W_REM{1'b0}};
            cnt_q       <= {W_CNT{1'b0}};
            euros_q     <= {W_IN{1'b0}};
            cents_q     <= {W_REM{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            euros_q     <= euros_d;
            cents_q     <= cents_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
